// File: rtl/serialize.sv
// serialize: takes a packed vector of up to N words per din handshake and
// emits the words one per dout handshake, least-significant word first,
// flagging the last word with eot. dout word/eot/valid come straight from
// flops; din_ready_o depends combinationally on dout_ready_i only while the
// last word of a vector is presented.
module serialize #(
  parameter int W_DATA = 16,
  parameter int N      = 4,
  parameter int W_LEN  = $clog2(N+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W_LEN+N*W_DATA-1:0] din_data_i,
  input  logic                      din_valid_i,
  output logic                      din_ready_o,
  output logic [W_DATA:0]           dout_data_o,
  output logic                      dout_valid_o,
  input  logic                      dout_ready_i
);

  localparam int W_IDX = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q, state_d;
  logic [W_IDX-1:0]           idx_q, idx_d, idx_nx;
  logic [W_LEN-1:0]           len_q, len_d, len_in, len_eff;
  logic [N-1:0][W_DATA-1:0]   items_q, items_d, din_items;
  logic [W_DATA-1:0]          word_q, word_d;
  logic                       eot_q, eot_d;
  logic                       vld_q, vld_d;
  logic                       xfer, acc, load;

  assign dout_data_o  = {eot_q, word_q};
  assign dout_valid_o = vld_q;

  // Handshakes, length clamp and next-state/next-word selection.
  always_comb begin
    len_in    = din_data_i[N*W_DATA +: W_LEN];
    len_eff   = (len_in > W_LEN'(N)) ? W_LEN'(N) : len_in;
    din_items = din_data_i[N*W_DATA-1:0];
    xfer      = vld_q & dout_ready_i;
    // A new vector may enter only when nothing is held or the held one
    // is handing over its final word this very cycle.
    din_ready_o = (state_q == IDLE) | (xfer & eot_q);
    acc       = din_valid_i & din_ready_o;
    // len==0 vectors are swallowed without ever touching the output.
    load      = acc & (len_eff != '0);
    idx_nx    = idx_q + 1'b1;

    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    items_d = items_q;
    word_d  = word_q;
    eot_d   = eot_q;
    vld_d   = vld_q;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (xfer) begin
          if (!eot_q) begin
            idx_d  = idx_nx;
            word_d = items_q[idx_nx];
            eot_d  = (W_LEN'(idx_nx) == len_q - 1'b1);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    // Accepting a vector overrides the drain-to-IDLE above so the first
    // word follows the previous eot with no bubble.
    if (load) begin
      state_d = SEND;
      idx_d   = '0;
      len_d   = len_eff;
      items_d = din_items;
      word_d  = din_items[0];
      eot_d   = (len_eff == W_LEN'(1));
      vld_d   = 1'b1;
    end
  end

  // Control state: reset drops any held vector without emitting eot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  // Datapath registers: content is don't-care while vld_q is low.
  always_ff @(posedge clk) begin
    len_q   <= len_d;
    items_q <= items_d;
    word_q  <= word_d;
    eot_q   <= eot_d;
  end

endmodule

// File: tb/tb_serialize.sv
// Directed bench for serialize (N=4, W_DATA=16) plus a randomized
// handshake run checked against a word scoreboard.
module tb_serialize;

  localparam int W_DATA = 16;
  localparam int N      = 4;
  localparam int W_LEN  = 3;

  logic                      clk;
  logic                      rst;
  logic [W_LEN+N*W_DATA-1:0] din_data;
  logic                      din_valid;
  logic                      din_ready;
  logic [W_DATA:0]           dout_data;
  logic                      dout_valid;
  logic                      dout_ready;

  int checks   = 0;
  int failures = 0;

  serialize #(.W_DATA(W_DATA), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_data_i  (din_data),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .dout_data_o (dout_data),
    .dout_valid_o(dout_valid),
    .dout_ready_i(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W_LEN+N*W_DATA-1:0] vec(input int len,
      input logic [15:0] w0, input logic [15:0] w1,
      input logic [15:0] w2, input logic [15:0] w3);
    logic [W_LEN-1:0] l;
    l = W_LEN'(len);
    return {l, w3, w2, w1, w0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check presented output word (only when valid expected) and din_ready.
  task automatic out(input string tag, input logic v, input logic eot,
                     input logic [15:0] w, input logic rdy);
    chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
    if (v) chk({tag, ".data"}, 32'(dout_data), {15'd0, eot, w});
    chk({tag, ".din_ready"}, 32'(din_ready), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] sbq[$];
  logic [16:0] got;
  logic [15:0] rw[4];
  int          rlen, sent, cyc, neff;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    out("reset", 1'b0, 1'b0, 16'h0, 1'b1);

    // 1: single vector len=4
    din_valid = 1'b1; din_data = vec(4, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    dout_ready = 1'b1;
    #1; chk("t1.ready_idle", 32'(din_ready), 32'd1);
    tick(); din_valid = 1'b0; #1;
    out("t1.w0", 1, 0, 16'h0001, 0);
    tick(); out("t1.w1", 1, 0, 16'h0002, 0);
    tick(); out("t1.w2", 1, 0, 16'h0003, 0);
    tick(); out("t1.w3", 1, 1, 16'h0004, 1);
    tick(); out("t1.done", 0, 0, 16'h0, 1);

    // 2: back-to-back with din_valid held high
    din_valid = 1'b1; din_data = vec(4, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
    tick();
    din_data = vec(2, 16'h00B0, 16'h00B1, 16'h0, 16'h0); #1;
    out("t2.a0", 1, 0, 16'h00A0, 0);
    tick(); out("t2.a1", 1, 0, 16'h00A1, 0);
    tick(); out("t2.a2", 1, 0, 16'h00A2, 0);
    tick(); out("t2.a3", 1, 1, 16'h00A3, 1);
    tick(); din_valid = 1'b0; #1;
    out("t2.b0", 1, 0, 16'h00B0, 0);
    tick(); out("t2.b1", 1, 1, 16'h00B1, 1);
    tick(); out("t2.done", 0, 0, 16'h0, 1);

    // 3: backpressure, ready pattern 1,0,0,1,1
    din_valid = 1'b1; din_data = vec(3, 16'h00C0, 16'h00C1, 16'h00C2, 16'h0);
    tick(); din_valid = 1'b0; dout_ready = 1'b1; #1;
    out("t3.c0", 1, 0, 16'h00C0, 0);
    tick(); dout_ready = 1'b0; #1; out("t3.c1_hold0", 1, 0, 16'h00C1, 0);
    tick(); out("t3.c1_hold1", 1, 0, 16'h00C1, 0);
    dout_ready = 1'b1; #1; out("t3.c1_go", 1, 0, 16'h00C1, 0);
    tick(); out("t3.c2", 1, 1, 16'h00C2, 1);
    tick(); out("t3.done", 0, 0, 16'h0, 1);
    // eot held under backpressure keeps din_ready low
    din_valid = 1'b1; din_data = vec(1, 16'h00C9, 16'h0, 16'h0, 16'h0);
    tick(); din_valid = 1'b0; dout_ready = 1'b0; #1;
    out("t3.eot_stall", 1, 1, 16'h00C9, 0);
    tick(); out("t3.eot_stall2", 1, 1, 16'h00C9, 0);
    dout_ready = 1'b1;
    tick(); out("t3.eot_done", 0, 0, 16'h0, 1);

    // 4: length edges
    din_valid = 1'b1; din_data = vec(0, 16'hDEAD, 16'h0, 16'h0, 16'h0);
    tick(); din_valid = 1'b0; #1;
    out("t4.len0", 0, 0, 16'h0, 1);
    tick(); out("t4.len0b", 0, 0, 16'h0, 1);
    din_valid = 1'b1; din_data = vec(1, 16'h00D0, 16'h00D1, 16'h0, 16'h0);
    tick(); din_valid = 1'b0; #1;
    out("t4.len1", 1, 1, 16'h00D0, 1);
    tick(); out("t4.len1_done", 0, 0, 16'h0, 1);
    din_valid = 1'b1; din_data = vec(7, 16'h00E0, 16'h00E1, 16'h00E2, 16'h00E3);
    tick(); din_valid = 1'b0; #1;
    out("t4.len7_w0", 1, 0, 16'h00E0, 0);
    tick(); out("t4.len7_w1", 1, 0, 16'h00E1, 0);
    tick(); out("t4.len7_w2", 1, 0, 16'h00E2, 0);
    tick(); out("t4.len7_w3", 1, 1, 16'h00E3, 1);
    tick(); out("t4.len7_done", 0, 0, 16'h0, 1);

    // 5: reset mid-vector
    din_valid = 1'b1; din_data = vec(4, 16'h0F00, 16'h0F01, 16'h0F02, 16'h0F03);
    tick(); din_valid = 1'b0; #1;
    out("t5.w0", 1, 0, 16'h0F00, 0);
    tick(); out("t5.w1", 1, 0, 16'h0F01, 0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    out("t5.after_rst", 0, 0, 16'h0, 1);
    din_valid = 1'b1; din_data = vec(2, 16'h0A10, 16'h0A11, 16'h0, 16'h0);
    tick(); din_valid = 1'b0; #1;
    out("t5.n0", 1, 0, 16'h0A10, 0);
    tick(); out("t5.n1", 1, 1, 16'h0A11, 1);
    tick(); out("t5.done", 0, 0, 16'h0, 1);

    // 6: random handshakes, 1000 vectors, scoreboard
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 40000) begin
      if (!din_valid && ($urandom_range(0, 1) == 1)) begin
        rlen = $urandom_range(0, N);
        for (int i = 0; i < 4; i++) rw[i] = 16'($urandom);
        din_data  = vec(rlen, rw[0], rw[1], rw[2], rw[3]);
        din_valid = 1'b1;
      end
      dout_ready = ($urandom_range(0, 1) == 1);
      #2;
      if (dout_valid && dout_ready) begin
        if (sbq.size() == 0) chk("rnd.unexpected_word", 32'(dout_data), 32'h1ffff);
        else begin
          got = sbq.pop_front();
          chk("rnd.word", 32'(dout_data), 32'(got));
        end
      end
      if (din_valid && din_ready) begin
        neff = rlen;
        for (int i = 0; i < neff; i++)
          sbq.push_back({(i == neff - 1), rw[i]});
        sent++;
      end
      tick();
      if (din_valid && sent > 0 && din_data === vec(rlen, rw[0], rw[1], rw[2], rw[3])) begin
        // vector stays presented until accepted; cleared once counted
      end
      cyc++;
      if (din_valid && din_ready_was_acc()) din_valid = 1'b0;
    end
    din_valid = 1'b0; dout_ready = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 100) begin
      #2;
      if (dout_valid) begin
        got = sbq.pop_front();
        chk("rnd.drain", 32'(dout_data), 32'(got));
      end
      tick();
      cyc++;
    end
    chk("rnd.sent", 32'(sent), 32'd1000);
    chk("rnd.leftover", 32'(sbq.size()), 32'd0);
    out("rnd.idle", 0, 0, 16'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Tracks whether the vector on din was taken at the last edge.
  logic acc_seen;
  always @(posedge clk) acc_seen = din_valid && din_ready;
  function automatic logic din_ready_was_acc();
    return acc_seen;
  endfunction

endmodule
